// File: rtl/ser_frame_pkg.sv
// Shared types and constants for the framed serial receiver.
// The optional parity stage is enabled with the SER_FRAME_PARITY_EN macro.
package ser_frame_pkg;

  // Controller states. PARITY is only reachable when the parity bit is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Data bits per frame when the instantiating design does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // The bit counter must hold every value from 0 up to and including the frame width.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_shift_unit.sv
// WIDTH-bit serial-to-parallel shift register with a direction select.
// A first-bit load clears the register apart from the incoming bit, so a new
// frame never inherits bits from an aborted one. The port exposes the value the
// register takes on the coming edge, so the controller can hand over a completed
// word on the same edge that accepts its final bit.
module ser_shift_unit
  import ser_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             shift_en_in,
  input  logic             load_first_in,
  input  logic             lsb_first_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_data_out
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // LSB-first frames enter at the MSB and move right, so the first bit ends
  // up in bit 0. MSB-first frames enter at the LSB and move left.
  always_comb begin
    shift_d = shift_q;
    if (load_first_in) begin
      if (lsb_first_in) begin
        shift_d = {bit_in, {(WIDTH-1){1'b0}}};
      end else begin
        shift_d = {{(WIDTH-1){1'b0}}, bit_in};
      end
    end else if (shift_en_in) begin
      if (lsb_first_in) begin
        shift_d = {bit_in, shift_q[WIDTH-1:1]};
      end else begin
        shift_d = {shift_q[WIDTH-2:0], bit_in};
      end
    end
  end

  // Shift register storage; reset discards any partial frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign next_data_out = shift_d;

endmodule

// File: rtl/ser_frame_rx_ctrl.sv
// Framed serial receiver controller: qualifies strobed bits, aligns on a
// frame-start marker, assembles WIDTH-bit words and offers them to a
// valid/ready consumer, flagging words dropped because the consumer stalled.
// Define SER_FRAME_PARITY_EN to expect a trailing even-parity bit per frame.
module ser_frame_rx_ctrl
  import ser_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ser_in,
  input  logic             bit_vld_in,
  input  logic             frame_start_in,
  input  logic             lsb_first_in,
  input  logic             par_ready_in,
  input  logic             overrun_clr_in,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid_out,
  output logic             busy_out,
  output logic             overrun_out,
  output logic [CNT_W-1:0] frame_cnt_out,
  output logic             parity_err_out
);

  localparam int CW = cntWidth(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lsb_q, lsb_d;

  logic [WIDTH-1:0] par_q;
  logic             valid_q;
  logic             ovr_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic             startBit;
  logic             shiftEn;
  logic             loadFirst;
  logic             complete;
  logic             transfer;
  logic             canLoad;
  logic             shiftDir;
  logic [WIDTH-1:0] word;

  assign startBit = bit_vld_in & frame_start_in;
  assign transfer = valid_q & par_ready_in;
  assign canLoad  = ~valid_q | par_ready_in;

  // A first bit uses the direction presented with it; later bits follow the
  // direction latched for the frame.
  assign shiftDir = loadFirst ? lsb_first_in : lsb_q;

  ser_shift_unit #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .shift_en_in   (shiftEn),
    .load_first_in (loadFirst),
    .lsb_first_in  (shiftDir),
    .bit_in        (ser_in),
    .next_data_out (word)
  );

  // Next-state logic. A marked bit always starts a fresh frame, whatever the
  // current state, which gives resync on a stray marker for free. The shift
  // register holds during PARITY, so its next value is still the data word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lsb_d     = lsb_q;
    shiftEn   = 1'b0;
    loadFirst = 1'b0;
    complete  = 1'b0;
    if (startBit) begin
      loadFirst = 1'b1;
      lsb_d     = lsb_first_in;
      cnt_d     = CW'(1);
      state_d   = SHIFT;
    end else if (bit_vld_in) begin
      unique case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          shiftEn = 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
`ifdef SER_FRAME_PARITY_EN
            cnt_d   = CW'(WIDTH);
            state_d = PARITY;
`else
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SER_FRAME_PARITY_EN
        PARITY: begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controller state, bit count and latched frame direction.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
    end
  end

  // Output word register and handshake. A completed word may only replace
  // par_out if the slot is empty or being drained on this very edge;
  // otherwise it is dropped and the overrun flag is raised (set beats clear).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      par_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (complete && canLoad) begin
        par_q   <= word;
        valid_q <= 1'b1;
      end else if (transfer) begin
        valid_q <= 1'b0;
      end
      if (transfer) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (complete && !canLoad) begin
        ovr_q <= 1'b1;
      end else if (overrun_clr_in) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef SER_FRAME_PARITY_EN
  logic perr_q;

  // Even-parity status travels with the word it describes, so it is only
  // updated when par_out is.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perr_q <= 1'b0;
    end else if (complete && canLoad) begin
      perr_q <= (^word) ^ ser_in;
    end
  end

  assign parity_err_out = perr_q;
`else
  assign parity_err_out = 1'b0;
`endif

  assign par_out       = par_q;
  assign par_valid_out = valid_q;
  assign busy_out      = (state_q != IDLE);
  assign overrun_out   = ovr_q;
  assign frame_cnt_out = frame_cnt_q;

endmodule

// File: tb/tb_ser_frame_rx_ctrl.sv
// Self-checking bench for ser_frame_rx_ctrl (WIDTH = 8, CNT_W = 8).
// Follows SER_FRAME_PARITY_EN so frames carry a trailing parity bit when defined.
module tb_ser_frame_rx_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
`ifdef SER_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             ser_in;
  logic             bit_vld_in;
  logic             frame_start_in;
  logic             lsb_first_in;
  logic             par_ready_in;
  logic             overrun_clr_in;
  logic [WIDTH-1:0] par_out;
  logic             par_valid_out;
  logic             busy_out;
  logic             overrun_out;
  logic [CNT_W-1:0] frame_cnt_out;
  logic             parity_err_out;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [CNT_W-1:0] expCnt;

  typedef struct {
    logic       ser;
    logic       vld;
    logic       start;
    logic       lsb;
    logic       rdy;
    logic       clr;
    logic [7:0] ePar;
    logic       eValid;
    logic       eBusy;
    logic       eOvr;
    logic [7:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_in = ~clk_in;

  ser_frame_rx_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .ser_in         (ser_in),
    .bit_vld_in     (bit_vld_in),
    .frame_start_in (frame_start_in),
    .lsb_first_in   (lsb_first_in),
    .par_ready_in   (par_ready_in),
    .overrun_clr_in (overrun_clr_in),
    .par_out        (par_out),
    .par_valid_out  (par_valid_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out),
    .frame_cnt_out  (frame_cnt_out),
    .parity_err_out (parity_err_out)
  );

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] ePar, input logic eValid,
                             input logic eBusy, input logic eOvr, input logic [7:0] eCnt);
    checkVal($sformatf("%s par_out", tag), par_out, ePar);
    checkVal($sformatf("%s par_valid", tag), par_valid_out, eValid);
    checkVal($sformatf("%s busy", tag), busy_out, eBusy);
    checkVal($sformatf("%s overrun", tag), overrun_out, eOvr);
    checkVal($sformatf("%s frame_cnt", tag), frame_cnt_out, eCnt);
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit later.
  task automatic applyStimulus(input logic s, input logic v, input logic st,
                               input logic lsb, input logic rdy, input logic clr);
    ser_in         = s;
    bit_vld_in     = v;
    frame_start_in = st;
    lsb_first_in   = lsb;
    par_ready_in   = rdy;
    overrun_clr_in = clr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, clr);
  endtask

  // Send a whole frame on consecutive cycles. rdyLast/clrLast apply to the
  // cycle that completes the frame (last data bit, or the parity bit).
  task automatic sendFrame(input logic [WIDTH-1:0] word, input logic lsb, input logic rdyBody,
                           input logic rdyLast, input logic clrLast, input logic parBit);
    logic b;
    logic isLast;
    for (int i = 0; i < WIDTH; i++) begin
      b      = lsb ? word[i] : word[WIDTH-1-i];
      isLast = (i == WIDTH-1) && !PAR_EN;
      applyStimulus(b, 1'b1, (i == 0), lsb, isLast ? rdyLast : rdyBody, isLast ? clrLast : 1'b0);
    end
    if (PAR_EN) begin
      applyStimulus(parBit, 1'b1, 1'b0, lsb, rdyLast, clrLast);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] seq;
    logic [4:0] bits5;
    logic       last;
    vec_t       v;

    rst_in = 1'b1;
    ser_in = 1'b0; bit_vld_in = 1'b0; frame_start_in = 1'b0;
    lsb_first_in = 1'b0; par_ready_in = 1'b0; overrun_clr_in = 1'b0;
    expCnt = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkVal("reset parity_err", parity_err_out, 0);
    rst_in = 1'b0;
    idle(1'b0, 1'b0);

    // Vector table: LSB-first frame 1,0,1,1,0,0,1,0 -> 8'h4D, then drained.
    seq = 8'h4D;
    for (int i = 0; i < WIDTH; i++) begin
      last = (i == WIDTH-1) && !PAR_EN;
      v = '{seq[i], 1'b1, (i == 0), 1'b1, 1'b1, 1'b0,
            last ? seq : 8'h00, last, !last, 1'b0, 8'h00};
      vecs.push_back(v);
    end
    if (PAR_EN) begin
      v = '{^seq, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, seq, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs.push_back(v);
    end
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, seq, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs.push_back(v);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ser, vecs[i].vld, vecs[i].start, vecs[i].lsb, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePar, vecs[i].eValid, vecs[i].eBusy,
                  vecs[i].eOvr, vecs[i].eCnt);
    end
    expCnt = 8'd1;

    // MSB-first, same bit order, 3 idle cycles between bits -> 8'hB2.
    seq = 8'hB2;
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(seq[WIDTH-1-i], 1'b1, (i == 0), 1'b0, 1'b1, 1'b0);
      if (i < WIDTH-1 || PAR_EN) begin
        checkVal("gap busy after bit", busy_out, 1);
        checkVal("gap valid after bit", par_valid_out, 0);
        repeat (3) begin
          idle(1'b1, 1'b0);
          checkVal("gap busy idle", busy_out, 1);
        end
      end
    end
    if (PAR_EN) applyStimulus(^seq, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("msb first", 8'hB2, 1'b1, 1'b0, 1'b0, expCnt);
    idle(1'b1, 1'b0);
    expCnt++;
    checkOutput("msb xfer", 8'hB2, 1'b0, 1'b0, 1'b0, expCnt);

    // Stalled consumer: second word dropped, overrun raised then cleared.
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, ^8'hA5);
    checkOutput("stall first", 8'hA5, 1'b1, 1'b0, 1'b0, expCnt);
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, ^8'h3C);
    checkOutput("stall drop", 8'hA5, 1'b1, 1'b0, 1'b1, expCnt);
    idle(1'b0, 1'b1);
    checkOutput("overrun clear", 8'hA5, 1'b1, 1'b0, 1'b0, expCnt);
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, ^8'h3C);
    expCnt++;
    checkOutput("ready at completion", 8'h3C, 1'b1, 1'b0, 1'b0, expCnt);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, ^8'h5A);
    checkOutput("set beats clear", 8'h3C, 1'b1, 1'b0, 1'b1, expCnt);
    idle(1'b0, 1'b1);
    checkOutput("clear again", 8'h3C, 1'b1, 1'b0, 1'b0, expCnt);
    idle(1'b1, 1'b0);
    expCnt++;
    checkOutput("stall xfer", 8'h3C, 1'b0, 1'b0, 1'b0, expCnt);

    // Resync: 5 bits of a frame, then a marked full frame of ones.
    bits5 = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bits5[i], 1'b1, (i == 0), 1'b1, 1'b1, 1'b0);
    end
    checkOutput("partial", 8'h3C, 1'b0, 1'b1, 1'b0, expCnt);
    sendFrame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("resync", 8'hFF, 1'b1, 1'b0, 1'b0, expCnt);
    idle(1'b1, 1'b0);
    expCnt++;
    checkOutput("resync xfer", 8'hFF, 1'b0, 1'b0, 1'b0, expCnt);

    // Asynchronous reset between edges, mid-frame.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
    end
    checkVal("pre-reset busy", busy_out, 1);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("async reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    checkVal("async reset parity_err", parity_err_out, 0);
    rst_in = 1'b0;
    expCnt = '0;
    idle(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("unmarked bits ignored", busy_out, 0);

    // Counter wrap: 255 words then one more.
    for (int k = 0; k < 255; k++) begin
      seq = 8'(k);
      sendFrame(seq, 1'b1, 1'b1, 1'b1, 1'b0, ^seq);
    end
    idle(1'b1, 1'b0);
    checkVal("cnt 255", frame_cnt_out, 8'hFF);
    sendFrame(8'h96, 1'b1, 1'b1, 1'b1, 1'b0, ^8'h96);
    idle(1'b1, 1'b0);
    checkVal("cnt wrap", frame_cnt_out, 8'h00);
    checkVal("wrap last word", par_out, 8'h96);
    checkVal("wrap overrun", overrun_out, 0);

    // Parity status.
`ifdef SER_FRAME_PARITY_EN
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("parity good word", par_out, 8'h07);
    checkVal("parity good", parity_err_out, 0);
    idle(1'b1, 1'b0);
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("parity bad word", par_out, 8'h07);
    checkVal("parity bad", parity_err_out, 1);
    checkVal("parity bad still valid", par_valid_out, 1);
    idle(1'b1, 1'b0);
`else
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("no parity word", par_out, 8'h07);
    checkVal("parity tied low", parity_err_out, 0);
    idle(1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
